// File: rtl/grf_wb_arbiter_pkg.sv
// Shared widths, FSM encodings and defaults for the GRF writeback arbiter.
package grf_wb_arbiter_pkg;

    localparam int REG_W              = 5;
    localparam int DATA_W             = 32;
    localparam int NUM_REGS           = 32;
    localparam int CNT_W              = 3;
    localparam int STARVE_LIMIT_DEF   = 4;

    // Anti-starvation FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/grf_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for MDU destinations: gates issue and raises
// the decode-stage stall for sources whose MDU result has not landed yet.
module grf_scoreboard
    import grf_wb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [REG_W-1:0] iss_addr,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_addr,
    input  logic [REG_W-1:0] rd_rs,
    input  logic [REG_W-1:0] rd_rt,
    output logic             iss_ready,
    output logic             rd_stall
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                set_en;

    // Issue handshake and stall are derived from the registered pending vector.
    always_comb begin
        iss_ready = !reset && (iss_addr == '0 || !pending[iss_addr]);
        set_en    = iss_valid && iss_ready && iss_addr != '0;
        rd_stall  = !reset && ((rd_rs != '0 && pending[rd_rs]) ||
                               (rd_rt != '0 && pending[rd_rt]));
    end

    // Next pending vector: set on issue, then clear on MDU write so a clear wins.
    always_comb begin
        // NOTE: default the whole vector first so no path leaves it unassigned (no latch).
        pending_nxt = pending;
        if (set_en) pending_nxt[iss_addr] = 1'b1;
        if (clr_en) pending_nxt[clr_addr] = 1'b0;
        pending_nxt[0] = 1'b0;
    end

    // Pending register; it is control state, so it is cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) pending <= '0;
        else       pending <= pending_nxt;
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Single GRF write-port arbiter: W-stage writeback has priority, the MDU
// is served otherwise, and a starvation FSM forces one MDU slot when the
// MDU has been refused STARVE_LIMIT consecutive cycles.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [REG_W-1:0]  pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic [DATA_W-1:0] pipe_pc,
    output logic              pipe_hold,
    input  logic              mdu_valid,
    input  logic [REG_W-1:0]  mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    input  logic [DATA_W-1:0] mdu_pc,
    output logic              mdu_ready,
    input  logic              iss_valid,
    input  logic [REG_W-1:0]  iss_addr,
    output logic              iss_ready,
    input  logic [REG_W-1:0]  rd_rs,
    input  logic [REG_W-1:0]  rd_rt,
    output logic              rd_stall,
    output logic              grf_we,
    output logic [REG_W-1:0]  grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    arb_state_e       state;
    logic [CNT_W-1:0] starve_cnt;

    logic pipe_req;
    logic mdu_req;
    logic force_grant;
    logic pipe_grant;
    logic mdu_grant;
    logic mdu_refused;

    // Grant decision from current state and effective requests.
    always_comb begin
        pipe_req    = pipe_we && pipe_addr != '0;
        mdu_req     = mdu_valid && mdu_addr != '0;
        force_grant = state == ST_FORCE && mdu_req;
        pipe_grant  = 1'b0;
        mdu_grant   = 1'b0;
        if (!reset) begin
            if (force_grant)  mdu_grant  = 1'b1;
            else if (pipe_req) pipe_grant = 1'b1;
            else if (mdu_req)  mdu_grant  = 1'b1;
        end
        mdu_refused = !reset && mdu_req && !mdu_grant;
    end

    // Handshakes and the GRF write-port mux; a write to $0 is acknowledged but dropped.
    always_comb begin
        pipe_hold = !reset && force_grant && pipe_req;
        mdu_ready = mdu_grant || (!reset && mdu_valid && mdu_addr == '0);
        grf_we    = pipe_grant || mdu_grant;
        grf_a3    = '0;
        grf_wd    = '0;
        grf_pc    = '0;
        if (pipe_grant) begin
            grf_a3 = pipe_addr;
            grf_wd = pipe_data;
            grf_pc = pipe_pc;
        end else if (mdu_grant) begin
            grf_a3 = mdu_addr;
            grf_wd = mdu_data;
            grf_pc = mdu_pc;
        end
    end

    // Starvation FSM and refusal counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            if (mdu_refused)
                starve_cnt <= (starve_cnt == CNT_SAT) ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;

            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (!mdu_refused)               state <= ST_IDLE;
                    else if (starve_cnt >= CNT_LAST) state <= ST_FORCE;
                    else                            state <= ST_WAIT;
                end
                ST_FORCE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    grf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .clr_en    (mdu_grant),
        .clr_addr  (mdu_addr),
        .rd_rs     (rd_rs),
        .rd_rt     (rd_rt),
        .iss_ready (iss_ready),
        .rd_stall  (rd_stall)
    );

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: inputs change 1 ns after posedge,
// outputs are sampled on the following negedge.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;
    logic        pipe_hold;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic        mdu_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic [4:0]  rd_rs;
    logic [4:0]  rd_rt;
    logic        rd_stall;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_we   (pipe_we),
        .pipe_addr (pipe_addr),
        .pipe_data (pipe_data),
        .pipe_pc   (pipe_pc),
        .pipe_hold (pipe_hold),
        .mdu_valid (mdu_valid),
        .mdu_addr  (mdu_addr),
        .mdu_data  (mdu_data),
        .mdu_pc    (mdu_pc),
        .mdu_ready (mdu_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .rd_rs     (rd_rs),
        .rd_rt     (rd_rt),
        .rd_stall  (rd_stall),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next drive point (just after posedge).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pipe_we = 0; pipe_addr = 0; pipe_data = 0; pipe_pc = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0; mdu_pc = 0;
        iss_valid = 0; iss_addr = 0; rd_rs = 0; rd_rt = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;

        // Reset with active inputs: every output quiet.
        next_cycle();
        pipe_we = 1; pipe_addr = 8; pipe_data = 32'h1111_1111;
        mdu_valid = 1; mdu_addr = 0;
        iss_valid = 1; iss_addr = 5; rd_rs = 5;
        sample();
        check("rst_grf_we",    32'(grf_we),    32'd0);
        check("rst_mdu_ready", 32'(mdu_ready), 32'd0);
        check("rst_pipe_hold", 32'(pipe_hold), 32'd0);
        check("rst_iss_ready", 32'(iss_ready), 32'd0);
        check("rst_rd_stall",  32'(rd_stall),  32'd0);

        // Idle after reset.
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        iss_addr = 5; rd_rs = 5;
        sample();
        check("idle_grf_we",    32'(grf_we),    32'd0);
        check("idle_rd_stall",  32'(rd_stall),  32'd0);
        check("idle_iss_ready", 32'(iss_ready), 32'd1);

        // Plain W-stage write.
        next_cycle();
        pipe_we = 1; pipe_addr = 8; pipe_data = 32'h1234_5678; pipe_pc = 32'h0000_3000;
        sample();
        check("pipe_grf_we",    32'(grf_we),    32'd1);
        check("pipe_grf_a3",    32'(grf_a3),    32'd8);
        check("pipe_grf_wd",    grf_wd,         32'h1234_5678);
        check("pipe_grf_pc",    grf_pc,         32'h0000_3000);
        check("pipe_hold0",     32'(pipe_hold), 32'd0);

        // Issue to $9; stall only from the next cycle.
        next_cycle();
        clear_inputs();
        iss_valid = 1; iss_addr = 9; rd_rs = 9;
        sample();
        check("iss9_ready",     32'(iss_ready), 32'd1);
        check("iss9_stall_now", 32'(rd_stall),  32'd0);

        // $9 pending: stall, and a re-issue is refused.
        next_cycle();
        iss_valid = 1; iss_addr = 9; rd_rs = 9;
        sample();
        check("p9_stall",       32'(rd_stall),  32'd1);
        check("reiss9_ready",   32'(iss_ready), 32'd0);

        // MDU writes $9 with the pipe idle.
        next_cycle();
        iss_valid = 0; iss_addr = 0;
        mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h0000_CAFE; mdu_pc = 32'h0000_3010;
        sample();
        check("m9_ready",       32'(mdu_ready), 32'd1);
        check("m9_grf_a3",      32'(grf_a3),    32'd9);
        check("m9_grf_wd",      grf_wd,         32'h0000_CAFE);
        check("m9_grf_pc",      grf_pc,         32'h0000_3010);
        check("m9_stall_grant", 32'(rd_stall),  32'd1);

        // Stall drops after the write; issue to $0 always accepted.
        next_cycle();
        clear_inputs();
        rd_rs = 9; rd_rt = 0; iss_valid = 1; iss_addr = 0;
        sample();
        check("m9_stall_after", 32'(rd_stall),  32'd0);
        check("iss0_ready",     32'(iss_ready), 32'd1);

        next_cycle();
        clear_inputs();
        sample();
        check("rt0_no_stall",   32'(rd_stall),  32'd0);

        // Starvation: 4 refusals, forced MDU slot on the 5th, pipe back on the 6th.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            pipe_we = 1; pipe_addr = 10; pipe_data = 32'hA000_0000 + 32'(i);
            mdu_valid = 1; mdu_addr = 3; mdu_data = 32'h0000_0333; mdu_pc = 32'h0000_4000;
            sample();
            check($sformatf("starve%0d_ready", i), 32'(mdu_ready), 32'd0);
            check($sformatf("starve%0d_a3", i),    32'(grf_a3),    32'd10);
            check($sformatf("starve%0d_hold", i),  32'(pipe_hold), 32'd0);
        end
        next_cycle();
        sample();
        check("force_hold",  32'(pipe_hold), 32'd1);
        check("force_a3",    32'(grf_a3),    32'd3);
        check("force_wd",    grf_wd,         32'h0000_0333);
        check("force_ready", 32'(mdu_ready), 32'd1);

        next_cycle();
        mdu_valid = 0; mdu_addr = 0;
        sample();
        check("post_force_a3",   32'(grf_a3),    32'd10);
        check("post_force_hold", 32'(pipe_hold), 32'd0);

        // Pipe write to $0 does not block the MDU.
        next_cycle();
        clear_inputs();
        pipe_we = 1; pipe_addr = 0; pipe_data = 32'hDEAD_BEEF;
        mdu_valid = 1; mdu_addr = 4; mdu_data = 32'h0000_0044;
        sample();
        check("p0_m4_a3",    32'(grf_a3),    32'd4);
        check("p0_m4_wd",    grf_wd,         32'h0000_0044);
        check("p0_m4_ready", 32'(mdu_ready), 32'd1);

        // MDU result for $0 is acknowledged without a GRF write.
        next_cycle();
        clear_inputs();
        mdu_valid = 1; mdu_addr = 0; mdu_data = 32'h5555_5555;
        sample();
        check("m0_ready", 32'(mdu_ready), 32'd1);
        check("m0_we",    32'(grf_we),    32'd0);

        next_cycle();
        pipe_we = 1; pipe_addr = 10;
        sample();
        check("m0_busy_ready", 32'(mdu_ready), 32'd1);
        check("m0_busy_a3",    32'(grf_a3),    32'd10);

        // Reset in WAIT with $7 pending.
        next_cycle();
        clear_inputs();
        iss_valid = 1; iss_addr = 7;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            clear_inputs();
            pipe_we = 1; pipe_addr = 10; mdu_valid = 1; mdu_addr = 3; rd_rs = 7;
            sample();
            check($sformatf("wait%0d_stall7", i), 32'(rd_stall),  32'd1);
            check($sformatf("wait%0d_ready", i),  32'(mdu_ready), 32'd0);
        end
        next_cycle();
        reset = 1'b1;
        sample();
        check("rst2_grf_we",    32'(grf_we),    32'd0);
        check("rst2_mdu_ready", 32'(mdu_ready), 32'd0);
        check("rst2_pipe_hold", 32'(pipe_hold), 32'd0);
        check("rst2_rd_stall",  32'(rd_stall),  32'd0);

        // After reset the counter restarts: again 4 refusals, forced on the 5th.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            reset = 1'b0;
            sample();
            if (i == 0) check("rst2_pending7", 32'(rd_stall), 32'd0);
            check($sformatf("restart%0d_ready", i), 32'(mdu_ready), (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("restart%0d_hold", i),  32'(pipe_hold), (i == 4) ? 32'd1 : 32'd0);
        end

        next_cycle();
        clear_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
